// File: rtl/apb_slave_regfile.sv
// APB completer with NUM_REGS RW registers, one RO status word, byte strobes,
// programmable wait states and pslverr; register contents drive peripheral logic.
module apb_slave_regfile #(
  parameter int unsigned      ADDR_W      = 32,
  parameter int unsigned      DATA_W      = 32,
  parameter int unsigned      NUM_REGS    = 8,
  parameter int unsigned      WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] RESET_VAL  = '0
) (
  input  logic                         s_apb_pclk_i,
  input  logic                         s_apb_preset_i,
  input  logic [ADDR_W-1:0]            s_apb_paddr_i,
  input  logic                         s_apb_psel_i,
  input  logic                         s_apb_penable_i,
  input  logic                         s_apb_pwrite_i,
  input  logic [DATA_W-1:0]            s_apb_pwdata_i,
  input  logic [DATA_W/8-1:0]          s_apb_pstrb_i,
  output logic                         s_apb_pready_o,
  output logic [DATA_W-1:0]            s_apb_prdata_o,
  output logic                         s_apb_pslverr_o,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o,
  input  logic [DATA_W-1:0]            status_i
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic [DATA_W-1:0] status_q, status_d;
  logic              err_q, err_d;
  logic              pready_q, pready_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              setup_c;
  logic [IDX_W-1:0]  setup_idx_c;
  logic              setup_err_c;
  logic [IDX_W-1:0]  sel_idx_c;
  logic [DATA_W-1:0] sel_status_c;
  logic [DATA_W-1:0] rdval_c;

  assign setup_c     = s_apb_psel_i & ~s_apb_penable_i;
  assign setup_idx_c = s_apb_paddr_i[ADDR_W-1:2];
  assign setup_err_c = (s_apb_paddr_i[1:0] != 2'b00)
                     || (setup_idx_c > IDX_W'(NUM_REGS))
                     || ((setup_idx_c == IDX_W'(NUM_REGS)) && s_apb_pwrite_i);

  // With zero wait states the response is formed straight from the setup phase.
  assign sel_idx_c    = (state_q == ST_IDLE) ? setup_idx_c : idx_q;
  assign sel_status_c = (state_q == ST_IDLE) ? status_i : status_q;

  always_comb begin
    rdval_c = '0;
    if (sel_idx_c == IDX_W'(NUM_REGS)) rdval_c = sel_status_c;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (sel_idx_c == IDX_W'(k)) rdval_c = regs_q[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    status_d   = status_q;
    err_d      = err_q;
    pready_d   = 1'b0;
    prdata_d   = '0;
    pslverr_d  = 1'b0;
    wr_pulse_d = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) regs_d[k] = regs_q[k];

    case (state_q)
      ST_IDLE: begin
        if (setup_c) begin
          idx_d    = setup_idx_c;
          write_d  = s_apb_pwrite_i;
          wdata_d  = s_apb_pwdata_i;
          strb_d   = s_apb_pstrb_i;
          status_d = status_i;
          err_d    = setup_err_c;
          if (WAIT_STATES == 0) begin
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = setup_err_c;
            prdata_d  = (setup_err_c || s_apb_pwrite_i) ? '0 : rdval_c;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (!s_apb_psel_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d   = ST_RESP;
          pready_d  = 1'b1;
          pslverr_d = err_q;
          prdata_d  = (err_q || write_q) ? '0 : rdval_c;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        // Commit only if the master is still in the access phase of a legal write.
        if (s_apb_psel_i && s_apb_penable_i && write_q && !err_q) begin
          for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (idx_q == IDX_W'(k)) begin
              wr_pulse_d[k] = 1'b1;
              for (int unsigned b = 0; b < STRB_W; b++) begin
                if (strb_q[b]) regs_d[k][b*8 +: 8] = wdata_q[b*8 +: 8];
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_apb_pclk_i) begin
    if (s_apb_preset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      status_q   <= '0;
      err_q      <= 1'b0;
      pready_q   <= 1'b0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      wr_pulse_q <= '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VAL;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      status_q   <= status_d;
      err_q      <= err_d;
      pready_q   <= pready_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
      wr_pulse_q <= wr_pulse_d;
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  assign s_apb_pready_o  = pready_q;
  assign s_apb_prdata_o  = prdata_q;
  assign s_apb_pslverr_o = pslverr_q;
  assign wr_pulse_o      = wr_pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (0, 1, 3 wait states) on a shared
// bus with private psel lines, checked against an array-based register model.
module tb_apb_slave_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] paddr;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] status;

  logic        pready  [3];
  logic [31:0] prdata  [3];
  logic        pslverr [3];
  logic [255:0] regs   [3];
  logic [7:0]  pulse   [3];

  int          ws_of [3] = '{1, 0, 3};
  logic [31:0] mregs [3][8];
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] status;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [7:0]  exp_pl;
  } vec_t;

  vec_t tbl [10];

  apb_slave_regfile #(.WAIT_STATES(1)) u_dut0 (
    .s_apb_pclk_i(clk), .s_apb_preset_i(rst), .s_apb_paddr_i(paddr),
    .s_apb_psel_i(psel[0]), .s_apb_penable_i(penable), .s_apb_pwrite_i(pwrite),
    .s_apb_pwdata_i(pwdata), .s_apb_pstrb_i(pstrb), .s_apb_pready_o(pready[0]),
    .s_apb_prdata_o(prdata[0]), .s_apb_pslverr_o(pslverr[0]), .regs_o(regs[0]),
    .wr_pulse_o(pulse[0]), .status_i(status));

  apb_slave_regfile #(.WAIT_STATES(0)) u_dut1 (
    .s_apb_pclk_i(clk), .s_apb_preset_i(rst), .s_apb_paddr_i(paddr),
    .s_apb_psel_i(psel[1]), .s_apb_penable_i(penable), .s_apb_pwrite_i(pwrite),
    .s_apb_pwdata_i(pwdata), .s_apb_pstrb_i(pstrb), .s_apb_pready_o(pready[1]),
    .s_apb_prdata_o(prdata[1]), .s_apb_pslverr_o(pslverr[1]), .regs_o(regs[1]),
    .wr_pulse_o(pulse[1]), .status_i(status));

  apb_slave_regfile #(.WAIT_STATES(3)) u_dut2 (
    .s_apb_pclk_i(clk), .s_apb_preset_i(rst), .s_apb_paddr_i(paddr),
    .s_apb_psel_i(psel[2]), .s_apb_penable_i(penable), .s_apb_pwrite_i(pwrite),
    .s_apb_pwdata_i(pwdata), .s_apb_pstrb_i(pstrb), .s_apb_pready_o(pready[2]),
    .s_apb_prdata_o(prdata[2]), .s_apb_pslverr_o(pslverr[2]), .regs_o(regs[2]),
    .wr_pulse_o(pulse[2]), .status_i(status));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] pack(input int d);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = mregs[d][k];
    return v;
  endfunction

  function automatic void clear_model();
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 8; k++) mregs[d][k] = 32'h0;
  endfunction

  // One full transfer; starts in the cycle it is called (setup), ends one cycle after pready.
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] sb, input logic [31:0] st,
                      output logic [31:0] rd, output logic er, output logic [7:0] pl);
    int          n;
    int          idx;
    logic        e;
    logic [31:0] exp_rd;
    logic [7:0]  exp_pl;
    idx    = int'(a[31:2]);
    e      = (a[1:0] != 2'b00) || (idx > 8) || (idx == 8 && w);
    exp_rd = 32'h0;
    exp_pl = 8'h0;
    if (!e && !w) begin
      if (idx == 8) exp_rd = st;
      else exp_rd = mregs[d][idx];
    end
    if (!e && w) exp_pl = 8'(1 << idx);
    paddr = a; pwrite = w; pwdata = wd; pstrb = sb; status = st;
    psel = 3'(1 << d); penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    status  = $urandom;
    n = 1;
    while (!pready[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 256'(n), 256'(ws_of[d] + 1));
    rd = prdata[d];
    er = pslverr[d];
    chk("prdata", 256'(rd), 256'(exp_rd));
    chk("pslverr", 256'(er), 256'(e));
    if (!e && w)
      for (int b = 0; b < 4; b++)
        if (sb[b]) mregs[d][idx][b*8 +: 8] = wd[b*8 +: 8];
    @(posedge clk); #1;
    psel = 3'b000; penable = 1'b0;
    pl = pulse[d];
    chk("wr_pulse", 256'(pl), 256'(exp_pl));
    chk("pready_drop", 256'(pready[d]), 256'(0));
    chk("prdata_drop", 256'(prdata[d]), 256'(0));
    chk("regs", regs[d], pack(d));
  endtask

  // Start a write to reg1 and kill it during the wait/response phase.
  task automatic abort_xfer(input int d, input bit use_rst);
    paddr = 32'h4; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    psel = 3'(1 << d); penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    if (ws_of[d] > 1) begin
      @(posedge clk); #1;
    end
    if (use_rst) rst = 1'b1;
    else psel = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0; psel = 3'b000; penable = 1'b0;
    if (use_rst) clear_model();
    for (int i = 0; i < 3; i++) begin
      chk("abort_pready", 256'(pready[d]), 256'(0));
      chk("abort_pulse", 256'(pulse[d]), 256'(0));
      @(posedge clk); #1;
    end
    chk("abort_regs", regs[d], pack(d));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [7:0]  pl;
    logic [31:0] a;
    logic [31:0] wd;
    int          d;

    tbl[0] = '{32'h08, 1'b1, 32'h1122_3344, 4'hF, 32'h0,        32'h0,        1'b0, 8'h04};
    tbl[1] = '{32'h08, 1'b1, 32'hDEAD_BEEF, 4'h5, 32'h0,        32'h0,        1'b0, 8'h04};
    tbl[2] = '{32'h08, 1'b0, 32'h0,         4'h0, 32'h0,        32'h11AD_33EF, 1'b0, 8'h00};
    tbl[3] = '{32'h20, 1'b0, 32'h0,         4'h0, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 8'h00};
    tbl[4] = '{32'h20, 1'b1, 32'h1234_5678, 4'hF, 32'hA5A5_0001, 32'h0,        1'b1, 8'h00};
    tbl[5] = '{32'h24, 1'b0, 32'h0,         4'h0, 32'h0,        32'h0,        1'b1, 8'h00};
    tbl[6] = '{32'h06, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0,        32'h0,        1'b1, 8'h00};
    tbl[7] = '{32'h00, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'h0,        32'h0,        1'b0, 8'h01};
    tbl[8] = '{32'h00, 1'b0, 32'h0,         4'h0, 32'h0,        32'h0,        1'b0, 8'h00};
    tbl[9] = '{32'h1C, 1'b1, 32'hCAFE_F00D, 4'hC, 32'h0,        32'h0,        1'b0, 8'h80};

    rst = 1'b1; paddr = '0; psel = '0; penable = 1'b0; pwrite = 1'b0;
    pwdata = '0; pstrb = '0; status = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_pready", 256'(pready[i]), 256'(0));
      chk("rst_prdata", 256'(prdata[i]), 256'(0));
      chk("rst_pslverr", 256'(pslverr[i]), 256'(0));
      chk("rst_pulse", 256'(pulse[i]), 256'(0));
      chk("rst_regs", regs[i], 256'(0));
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) begin
      xfer(0, 32'(k * 4), 1'b0, 32'h0, 4'h0, 32'h0, rd, er, pl);
      chk("t1_rd_zero", 256'(rd), 256'(0));
    end

    for (int i = 0; i < 10; i++) begin
      xfer(0, tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].strb, tbl[i].status, rd, er, pl);
      chk($sformatf("tbl%0d_rd", i), 256'(rd), 256'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d_err", i), 256'(er), 256'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_pl", i), 256'(pl), 256'(tbl[i].exp_pl));
    end
    chk("t2_reg2", 256'(regs[0][2*32 +: 32]), 256'(32'h11AD_33EF));

    // penable without a preceding setup must be ignored
    psel = 3'b001; penable = 1'b1; paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'h5555_5555; pstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("ign_pready", 256'(pready[0]), 256'(0));
      chk("ign_pulse", 256'(pulse[0]), 256'(0));
    end
    psel = 3'b000; penable = 1'b0;
    chk("ign_regs", regs[0], pack(0));

    // back-to-back write then read of reg5 on the 0 and 3 wait-state instances
    for (int dd = 1; dd < 3; dd++) begin
      wd = $urandom;
      xfer(dd, 32'h14, 1'b1, wd, 4'hF, 32'h0, rd, er, pl);
      xfer(dd, 32'h14, 1'b0, 32'h0, 4'h0, 32'h0, rd, er, pl);
      chk("t5_readback", 256'(rd), 256'(wd));
    end

    for (int i = 0; i < 3; i++) begin
      xfer(i, 32'h04, 1'b1, 32'h0BAD_F00D + 32'(i), 4'hF, 32'h0, rd, er, pl);
      abort_xfer(i, 1'b0);
    end
    abort_xfer(2, 1'b1);
    abort_xfer(0, 1'b1);
    xfer(0, 32'h04, 1'b1, 32'h7777_1111, 4'hF, 32'h0, rd, er, pl);
    xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, 32'h0, rd, er, pl);
    chk("t6_recover", 256'(rd), 256'(32'h7777_1111));

    for (int i = 0; i < 200; i++) begin
      d = $urandom_range(0, 2);
      a = 32'($urandom_range(0, 10) * 4);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      xfer(d, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, rd, er, pl);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
